// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback sources:
//   port A (ALU result) and port B (load unit). Each source hands entries over
//   with a valid/ready handshake into its own 1-entry holding buffer. Each cycle
//   one buffer is drained into a registered write stage. The older entry wins.
//   Entries that arrived on the same edge are ordered by a round-robin pointer.
//   The write stage drives the register file write port.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   a_valid/a_ready             port A handshake
//   a_rd_addr/a_data            port A destination register and data
//   b_valid/b_ready             port B handshake
//   b_rd_addr/b_data            port B destination register and data
//   write_reg                   register-file write enable (registered)
//   rd_addr/write_data          register-file write address/data (registered)
//   wb_pending                  a buffer or the write stage holds an entry
//
// Optional feature (macro REGFILE_WB_FWD_EN)
//   Adds rs1_addr/rs2_addr inputs and fwd1/fwd2 hit+data outputs. These bypass
//   the value that the write stage is writing this cycle to the two read ports.

module regfile_wb_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_SIZE-1:0] a_rd_addr,
    input  logic [DATA_SIZE-1:0] a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_SIZE-1:0] b_rd_addr,
    input  logic [DATA_SIZE-1:0] b_data,
    output logic                 write_reg,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] write_data,
    output logic                 wb_pending
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [ADDR_SIZE-1:0] rs1_addr,
    input  logic [ADDR_SIZE-1:0] rs2_addr,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DATA_SIZE-1:0] fwd1_data,
    output logic [DATA_SIZE-1:0] fwd2_data
`endif
);

    logic                 buf_a_valid, buf_b_valid;
    // age set: the other buffer holds an entry that arrived strictly earlier
    logic                 buf_a_age, buf_b_age;
    logic [ADDR_SIZE-1:0] buf_a_addr, buf_b_addr;
    logic [DATA_SIZE-1:0] buf_a_data, buf_b_data;
    logic                 rr_b;          // 1: port B wins the next tie
    logic                 grant_a, grant_b;
    logic                 tie;
    logic                 a_fire, b_fire;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [DATA_SIZE-1:0] sel_data;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        tie     = 1'b0;
        if (buf_a_valid && buf_b_valid) begin
            if (buf_a_age != buf_b_age) begin
                grant_a = buf_b_age;
                grant_b = buf_a_age;
            end else begin
                tie     = 1'b1;
                grant_a = !rr_b;
                grant_b = rr_b;
            end
        end else begin
            grant_a = buf_a_valid;
            grant_b = buf_b_valid;
        end
    end

    assign sel_addr = grant_b ? buf_b_addr : buf_a_addr;
    assign sel_data = grant_b ? buf_b_data : buf_a_data;

    // A buffer being drained this cycle can be refilled on the same edge.
    assign a_ready = rst_n && (!buf_a_valid || grant_a);
    assign b_ready = rst_n && (!buf_b_valid || grant_b);
    assign a_fire  = a_valid && a_ready;
    assign b_fire  = b_valid && b_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_a_valid <= 1'b0;
            buf_a_age   <= 1'b0;
            buf_a_addr  <= '0;
            buf_a_data  <= '0;
            buf_b_valid <= 1'b0;
            buf_b_age   <= 1'b0;
            buf_b_addr  <= '0;
            buf_b_data  <= '0;
            rr_b        <= 1'b0;
            write_reg   <= 1'b0;
            rd_addr     <= '0;
            write_data  <= '0;
        end else begin
            // A new entry is younger only if the other entry stays past this
            // edge; if the other entry drains on the same edge, a later arrival
            // on the other port does not count as older.
            if (a_fire) begin
                buf_a_valid <= 1'b1;
                buf_a_addr  <= a_rd_addr;
                buf_a_data  <= a_data;
                buf_a_age   <= buf_b_valid && !grant_b;
            end else if (grant_a) begin
                buf_a_valid <= 1'b0;
                buf_a_age   <= 1'b0;
            end else if (grant_b) begin
                buf_a_age   <= 1'b0;
            end

            if (b_fire) begin
                buf_b_valid <= 1'b1;
                buf_b_addr  <= b_rd_addr;
                buf_b_data  <= b_data;
                buf_b_age   <= buf_a_valid && !grant_a;
            end else if (grant_b) begin
                buf_b_valid <= 1'b0;
                buf_b_age   <= 1'b0;
            end else if (grant_a) begin
                buf_b_age   <= 1'b0;
            end

            if (tie) begin
                rr_b <= grant_a;
            end

            // x0 entries use up a slot but never assert the write enable.
            if (grant_a || grant_b) begin
                write_reg  <= (sel_addr != '0);
                rd_addr    <= sel_addr;
                write_data <= sel_data;
            end else begin
                write_reg  <= 1'b0;
            end
        end
    end

    assign wb_pending = buf_a_valid | buf_b_valid | write_reg;

`ifdef REGFILE_WB_FWD_EN
    assign fwd1_hit  = write_reg && (rd_addr == rs1_addr) && (rs1_addr != '0);
    assign fwd2_hit  = write_reg && (rd_addr == rs2_addr) && (rs2_addr != '0);
    assign fwd1_data = fwd1_hit ? write_data : '0;
    assign fwd2_data = fwd2_hit ? write_data : '0;
`endif

endmodule
